// File: rtl/prv32_alu_md.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prv32_alu_md : prv32 EX-stage ALU with iterative RV32M multiply/divide.  |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module prv32_alu_md #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alufn,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] r,
    output logic            cf,
    output logic            zf,
    output logic            vf,
    output logic            sf,
    output logic            busy
);

    localparam int                c_shw      = $clog2(XLEN);
    localparam int                c_cw       = $clog2(XLEN) + 1;
    localparam logic [c_cw-1:0]   c_mul_last = c_cw'(XLEN / MUL_STEP - 1);
    localparam logic [c_cw-1:0]   c_div_last = c_cw'(XLEN - 1);
    localparam logic [XLEN-1:0]   c_min      = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [XLEN-1:0]     r_res;
    logic                r_cf, r_zf, r_vf, r_sf;
    logic                r_out_valid;
    logic                r_busy;
    logic [2:0]          r_op;
    logic                r_negq;
    logic                r_negr;
    logic [c_cw-1:0]     r_cnt;
    logic [2*XLEN-1:0]   r_prod;
    logic [XLEN-1:0]     r_opnd;

    logic                w_accept;

    assign in_ready  = (r_state == S_IDLE) & (~r_out_valid | out_ready);
    assign w_accept  = in_valid & in_ready & ~kill;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign r         = r_res;
    assign cf        = r_cf;
    assign zf        = r_zf;
    assign vf        = r_vf;
    assign sf        = r_sf;

    // Base ALU: shared (XLEN+1)-bit adder drives flags and the compares.
    logic              w_sub;
    logic [XLEN-1:0]   w_bx;
    logic [XLEN:0]     w_add;
    logic              w_cf, w_zf, w_vf, w_sf;
    logic [c_shw-1:0]  w_shamt;
    logic [XLEN-1:0]   w_base_res;

    assign w_sub   = (alufn[3:0] == 4'b0001) | (alufn[3:0] == 4'b1101) |
                     (alufn[3:0] == 4'b1111);
    assign w_bx    = w_sub ? ~b : b;
    assign w_add   = {1'b0, a} + {1'b0, w_bx} + {{XLEN{1'b0}}, w_sub};
    assign w_cf    = w_add[XLEN];
    assign w_zf    = (w_add[XLEN-1:0] == '0);
    assign w_sf    = w_add[XLEN-1];
    assign w_vf    = (a[XLEN-1] == w_bx[XLEN-1]) & (w_add[XLEN-1] != a[XLEN-1]);
    assign w_shamt = b[c_shw-1:0];

    always_comb begin
        w_base_res = '0;
        case (alufn[3:0])
            4'b0000, 4'b0001: w_base_res = w_add[XLEN-1:0];
            4'b0011:          w_base_res = b;
            4'b0100:          w_base_res = a | b;
            4'b0101:          w_base_res = a & b;
            4'b0111:          w_base_res = a ^ b;
            4'b1000:          w_base_res = a >> w_shamt;
            4'b1001:          w_base_res = $signed(a) >>> w_shamt;
            4'b1010:          w_base_res = a << w_shamt;
            4'b1101:          w_base_res = {{(XLEN-1){1'b0}}, w_sf ^ w_vf};
            4'b1111:          w_base_res = {{(XLEN-1){1'b0}}, ~w_cf};
            default:          w_base_res = '0;
        endcase
    end

    // M-op launch: operand signedness by funct3, magnitudes, and the
    // divide cases that bypass iteration.
    logic              w_divop;
    logic              w_sa_en, w_sb_en, w_sa, w_sb;
    logic [XLEN-1:0]   w_amag, w_bmag;
    logic              w_dz, w_dovf, w_special;
    logic [XLEN-1:0]   w_spec_res;

    assign w_divop   = alufn[2];
    assign w_sa_en   = w_divop ? ~alufn[0] : (alufn[1:0] == 2'b01) | (alufn[1:0] == 2'b10);
    assign w_sb_en   = w_divop ? ~alufn[0] : (alufn[1:0] == 2'b01);
    assign w_sa      = w_sa_en & a[XLEN-1];
    assign w_sb      = w_sb_en & b[XLEN-1];
    assign w_amag    = w_sa ? -a : a;
    assign w_bmag    = w_sb ? -b : b;
    assign w_dz      = (b == '0);
    assign w_dovf    = ~alufn[0] & (a == c_min) & (b == '1);
    assign w_special = w_divop & (w_dz | w_dovf);

    always_comb begin
        w_spec_res = '0;
        if (alufn[1])
            w_spec_res = w_dz ? a : '0;
        else
            w_spec_res = w_dz ? '1 : a;
    end

    // Shift-add multiply: low half of r_prod holds the unretired multiplier.
    logic [XLEN+MUL_STEP-1:0] w_pp;
    logic [XLEN+MUL_STEP-1:0] w_msum;
    logic [2*XLEN-1:0]        w_mnext;

    assign w_pp    = {{MUL_STEP{1'b0}}, r_opnd} * {{XLEN{1'b0}}, r_prod[MUL_STEP-1:0]};
    assign w_msum  = {{MUL_STEP{1'b0}}, r_prod[2*XLEN-1:XLEN]} + w_pp;
    assign w_mnext = {w_msum, r_prod[XLEN-1:MUL_STEP]};

    // Restoring divide: high half is the partial remainder, low half shifts
    // dividend bits out and quotient bits in.
    logic [XLEN:0]      w_dsh;
    logic               w_dge;
    logic [XLEN-1:0]    w_ddif;
    logic [2*XLEN-1:0]  w_dnext;

    assign w_dsh   = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
    assign w_dge   = (w_dsh >= {1'b0, r_opnd});
    assign w_ddif  = w_dsh[XLEN-1:0] - r_opnd;
    assign w_dnext = {(w_dge ? w_ddif : w_dsh[XLEN-1:0]), r_prod[XLEN-2:0], w_dge};

    // Final step result is sign-corrected straight off the last iteration.
    logic [2*XLEN-1:0]  w_fin;
    logic [2*XLEN-1:0]  w_pfix;
    logic [XLEN-1:0]    w_quo, w_rem;
    logic [XLEN-1:0]    w_done_res;

    assign w_fin  = (r_state == S_DIV) ? w_dnext : w_mnext;
    assign w_pfix = r_negq ? -w_fin : w_fin;
    assign w_quo  = r_negq ? -w_fin[XLEN-1:0] : w_fin[XLEN-1:0];
    assign w_rem  = r_negr ? -w_fin[2*XLEN-1:XLEN] : w_fin[2*XLEN-1:XLEN];

    always_comb begin
        w_done_res = '0;
        case (r_op)
            3'b000:                 w_done_res = w_pfix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_done_res = w_pfix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_done_res = w_quo;
            default:                w_done_res = w_rem;
        endcase
    end

    logic w_last;
    assign w_last = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_res       <= '0;
            r_cf        <= 1'b0;
            r_zf        <= 1'b0;
            r_vf        <= 1'b0;
            r_sf        <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_op        <= '0;
            r_negq      <= 1'b0;
            r_negr      <= 1'b0;
            r_cnt       <= '0;
            r_prod      <= '0;
            r_opnd      <= '0;
        end else if (kill) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (r_out_valid && out_ready)
                r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!alufn[4]) begin
                            r_res       <= w_base_res;
                            r_cf        <= w_cf;
                            r_zf        <= w_zf;
                            r_vf        <= w_vf;
                            r_sf        <= w_sf;
                            r_out_valid <= 1'b1;
                        end else if (w_special) begin
                            r_res       <= w_spec_res;
                            r_cf        <= 1'b0;
                            r_vf        <= 1'b0;
                            r_zf        <= (w_spec_res == '0);
                            r_sf        <= w_spec_res[XLEN-1];
                            r_out_valid <= 1'b1;
                        end else begin
                            r_op   <= alufn[2:0];
                            r_negq <= w_sa ^ w_sb;
                            r_negr <= w_sa;
                            r_busy <= 1'b1;
                            if (w_divop) begin
                                r_prod  <= {{XLEN{1'b0}}, w_amag};
                                r_opnd  <= w_bmag;
                                r_cnt   <= c_div_last;
                                r_state <= S_DIV;
                            end else begin
                                r_prod  <= {{XLEN{1'b0}}, w_bmag};
                                r_opnd  <= w_amag;
                                r_cnt   <= c_mul_last;
                                r_state <= S_MUL;
                            end
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    r_prod <= w_fin;
                    if (w_last) begin
                        r_res       <= w_done_res;
                        r_cf        <= 1'b0;
                        r_vf        <= 1'b0;
                        r_zf        <= (w_done_res == '0);
                        r_sf        <= w_done_res[XLEN-1];
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - c_cw'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prv32_alu_md.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_prv32_alu_md : directed self-checking bench for prv32_alu_md.         |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_prv32_alu_md;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alufn;
    logic [31:0] a;
    logic [31:0] b;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] r;
    logic        cf, zf, vf, sf;
    logic        busy;

    int checks = 0;
    int errors = 0;

    prv32_alu_md #(.XLEN(32), .MUL_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alufn(alufn), .a(a), .b(b), .kill(kill), .out_valid(out_valid),
        .out_ready(out_ready), .r(r), .cf(cf), .zf(zf), .vf(vf), .sf(sf),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Presents an op, waits (bounded) for in_ready, and returns 1ns after
    // the accepting edge with in_valid dropped.
    task automatic issue(input logic [4:0] fn, input logic [31:0] xa, input logic [31:0] xb);
        int t;
        t = 0;
        alufn = fn; a = xa; b = xb; in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1; t++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // n counts cycles from the accept cycle to the first out_valid cycle.
    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_valid: out_valid=%b after %0d cycles required 1", out_valid, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1;
        alufn = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL reset_r: r=%h required 0", r); end
        checks++;
        if ({cf, zf, vf, sf} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: flags=%b required 0000", {cf, zf, vf, sf});
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_ctl: out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready); end
    endtask

    task automatic test_base();
        logic [4:0]  fn  [14];
        logic [31:0] va  [14];
        logic [31:0] vb  [14];
        logic [31:0] ex  [14];
        logic        fck [14];
        logic [3:0]  fex [14];
        fn  = '{5'h00, 5'h01, 5'h0F, 5'h09, 5'h08, 5'h0A, 5'h0D,
                5'h0D, 5'h04, 5'h05, 5'h07, 5'h03, 5'h02, 5'h0F};
        va  = '{32'h7FFFFFFF, 32'd5, 32'd1, 32'h80000000, 32'h80000000, 32'h3, 32'hFFFFFFFF,
                32'd1, 32'hF0F00000, 32'hFF00FF00, 32'hFFFF0000, 32'h12345678, 32'h1, 32'd2};
        vb  = '{32'd1, 32'd5, 32'd2, 32'd4, 32'd4, 32'h24, 32'd1,
                32'hFFFFFFFF, 32'h00000F0F, 32'h0F0F0F0F, 32'hFF00FF00, 32'hCAFEBABE, 32'h1, 32'd1};
        ex  = '{32'h80000000, 32'h0, 32'h1, 32'hF8000000, 32'h08000000, 32'h30, 32'h1,
                32'h0, 32'hF0F00F0F, 32'h0F000F00, 32'h00FFFF00, 32'hCAFEBABE, 32'h0, 32'h0};
        fck = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        // {cf, zf, vf, sf}
        fex = '{4'b0011, 4'b1100, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0,
                4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
        for (int i = 0; i < 14; i++) begin
            issue(fn[i], va[i], vb[i]);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL base_latency[%0d]: out_valid=%b required 1", i, out_valid);
            end
            checks++;
            if (r !== ex[i]) begin
                errors++; $display("FAIL base_r[%0d] fn=%h: r=%h required %h", i, fn[i], r, ex[i]);
            end
            if (fck[i]) begin
                checks++;
                if ({cf, zf, vf, sf} !== fex[i]) begin
                    errors++; $display("FAIL base_flags[%0d]: cf,zf,vf,sf=%b required %b", i, {cf, zf, vf, sf}, fex[i]);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        logic [4:0]  fn [4];
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] ex [4];
        int n;
        fn = '{5'h10, 5'h13, 5'h11, 5'h12};
        va = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFE};
        vb = '{32'd7,        32'hFFFFFFFF, 32'h80000000, 32'd3};
        ex = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF};
        for (int i = 0; i < 4; i++) begin
            issue(fn[i], va[i], vb[i]);
            if (i == 0) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy: busy=%b required 1", busy); end
            end
            wait_valid(n);
            checks++;
            if (n != 33) begin errors++; $display("FAIL mul_latency[%0d]: cycles=%0d required 33", i, n); end
            checks++;
            if (r !== ex[i]) begin
                errors++; $display("FAIL mul_r[%0d] fn=%h: r=%h required %h", i, fn[i], r, ex[i]);
            end
            if (i == 0) begin
                checks++;
                if ({cf, zf, vf, sf} !== 4'b0001 || busy !== 1'b0) begin
                    errors++; $display("FAIL mul_flags: cf,zf,vf,sf=%b busy=%b required 0001 0", {cf, zf, vf, sf}, busy);
                end
            end
        end
    endtask

    task automatic test_div();
        logic [4:0]  fn [10];
        logic [31:0] va [10];
        logic [31:0] vb [10];
        logic [31:0] ex [10];
        int          lat [10];
        int n;
        fn  = '{5'h14, 5'h16, 5'h14, 5'h16, 5'h15, 5'h17, 5'h15, 5'h16, 5'h14, 5'h16};
        va  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'd100, 32'd100, 32'd9, 32'd5,
                32'h80000000, 32'h80000000};
        vb  = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd7, 32'd7, 32'd0, 32'd0,
                32'hFFFFFFFF, 32'hFFFFFFFF};
        ex  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5,
                32'h80000000, 32'h0};
        lat = '{33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
        for (int i = 0; i < 10; i++) begin
            issue(fn[i], va[i], vb[i]);
            wait_valid(n);
            checks++;
            if (n != lat[i]) begin errors++; $display("FAIL div_latency[%0d]: cycles=%0d required %0d", i, n, lat[i]); end
            checks++;
            if (r !== ex[i]) begin
                errors++; $display("FAIL div_r[%0d] fn=%h: r=%h required %h", i, fn[i], r, ex[i]);
            end
        end
        checks++;
        if (zf !== 1'b1 || sf !== 1'b0) begin
            errors++; $display("FAIL div_rem_zero_flags: zf=%b sf=%b required 1 0", zf, sf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        issue(5'h14, 32'd100, 32'd7);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (r !== 32'd14 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: r=%h out_valid=%b in_ready=%b required 0000000e 1 0", i, r, out_valid, in_ready);
            end
        end
        alufn = 5'h00; a = 32'd2; b = 32'd2; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: in_ready=%b required 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (r !== 32'd4 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_release_accept: r=%h out_valid=%b required 00000004 1", r, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [4:0]  fn [3];
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] ex [3];
        fn = '{5'h00, 5'h01, 5'h07};
        va = '{32'd1, 32'd10, 32'hAAAA5555};
        vb = '{32'd2, 32'd4,  32'hFFFF0000};
        ex = '{32'd3, 32'd6,  32'h55555555};
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alufn = fn[i]; a = va[i]; b = vb[i];
            @(posedge clk); #1;
            checks++;
            if (r !== ex[i] || out_valid !== 1'b1 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d]: r=%h out_valid=%b in_ready=%b required %h 1 1", i, r, out_valid, in_ready, ex[i]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_kill();
        issue(5'h00, 32'd3, 32'd4);
        @(posedge clk); #1;
        issue(5'h15, 32'hFFFF0000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL kill_ctl: out_valid=%b busy=%b in_ready=%b required 0 0 1", out_valid, busy, in_ready);
        end
        checks++;
        if (r !== 32'd7) begin errors++; $display("FAIL kill_r_hold: r=%h required 00000007", r); end
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL kill_no_result: out_valid=%b required 0", out_valid); end
        alufn = 5'h00; a = 32'd5; b = 32'd5; in_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || r !== 32'd7) begin
            errors++; $display("FAIL kill_vs_valid: out_valid=%b r=%h required 0 00000007", out_valid, r);
        end
        issue(5'h00, 32'd1, 32'd1);
        checks++;
        if (r !== 32'd2 || out_valid !== 1'b1) begin
            errors++; $display("FAIL kill_after_add: r=%h out_valid=%b required 00000002 1", r, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        issue(5'h10, 32'd12345, 32'd678);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (r !== 32'h0 || out_valid !== 1'b0 || busy !== 1'b0 || {cf, zf, vf, sf} !== 4'b0) begin
            errors++;
            $display("FAIL reset_mid: r=%h out_valid=%b busy=%b flags=%b required 0 0 0 0000", r, out_valid, busy, {cf, zf, vf, sf});
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(5'h00, 32'd1, 32'd1);
        checks++;
        if (r !== 32'd2 || out_valid !== 1'b1) begin
            errors++; $display("FAIL reset_mid_add: r=%h out_valid=%b required 00000002 1", r, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_base();
        test_mul();
        test_div();
        test_backpressure();
        test_back_to_back();
        test_kill();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
